// File: rtl/inst_fetch_queue_pkg.sv
// inst_fetch_queue_pkg: shared bus widths, queue sizing and issue-count saturation helper
package inst_fetch_queue_pkg;
  localparam int INST_BUS_W = 32;
  localparam int INST_ADDR_BUS_W = 32;
  localparam int IFQ_DEPTH = 16;
  localparam int IFQ_PTR_W = $clog2(IFQ_DEPTH);
  function automatic logic [1:0] sat_issue(input logic [1:0] c);
    return c[1] ? 2'd2 : c;
  endfunction
endpackage

// File: rtl/inst_fetch_queue_storage.sv
// ifq_storage: entry array, 2 write ports, 2 asynchronous read ports, data not reset
// ports: clk; we1_i/wa1_i/wd1_i and we2_i/wa2_i/wd2_i write ports; ra1_i/rd1_o and ra2_i/rd2_o read ports
module ifq_storage
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int W = INST_BUS_W + INST_ADDR_BUS_W,
  parameter int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we1_i,
  input  logic [PW-1:0] wa1_i,
  input  logic [W-1:0]  wd1_i,
  input  logic          we2_i,
  input  logic [PW-1:0] wa2_i,
  input  logic [W-1:0]  wd2_i,
  input  logic [PW-1:0] ra1_i,
  output logic [W-1:0]  rd1_o,
  input  logic [PW-1:0] ra2_i,
  output logic [W-1:0]  rd2_o
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we1_i) mem_q[wa1_i] <= wd1_i;
    if (we2_i) mem_q[wa2_i] <= wd2_i;
  end
  assign rd1_o = mem_q[ra1_i];
  assign rd2_o = mem_q[ra2_i];
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: dual-in/dual-out circular instruction queue between fetch and decode
// ports: aclk, aresetn (async active-low), flush_i; in_valid/inst/addr 1,2 push slots; full_o;
//        issue_cnt_i pop count; out_valid/inst/addr 1,2 show-ahead head entries; count_o occupancy
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int IW = INST_BUS_W,
  parameter int AW = INST_ADDR_BUS_W
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   flush_i,
  input  logic                   in_valid1_i,
  input  logic [IW-1:0]          in_inst1_i,
  input  logic [AW-1:0]          in_addr1_i,
  input  logic                   in_valid2_i,
  input  logic [IW-1:0]          in_inst2_i,
  input  logic [AW-1:0]          in_addr2_i,
  output logic                   full_o,
  input  logic [1:0]             issue_cnt_i,
  output logic                   out_valid1_o,
  output logic [IW-1:0]          out_inst1_o,
  output logic [AW-1:0]          out_addr1_o,
  output logic                   out_valid2_o,
  output logic [IW-1:0]          out_inst2_o,
  output logic [AW-1:0]          out_addr2_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, pop_n;
  logic [1:0] push_n, iss;
  logic push_ok;
  logic [IW+AW-1:0] rd1, rd2;
  // full reserves room for a 2-wide push, so it depends on registered count only
  assign full_o = count_q > CW'(DEPTH - 2);
  assign push_ok = !full_o && !flush_i;
  assign iss = sat_issue(issue_cnt_i);
  always_comb begin
    push_n = push_ok ? {1'b0, in_valid1_i} + {1'b0, in_valid2_i} : 2'd0;
    pop_n = CW'(iss) > count_q ? count_q : CW'(iss);
    tail_d = tail_q + PW'(push_n);
    head_d = head_q + PW'(pop_n);
    count_d = count_q + CW'(push_n) - pop_n;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  // slots are packed: a lone slot 2 goes to tail through write port 1
  ifq_storage #(.DEPTH(DEPTH), .W(IW + AW), .PW(PW)) u_storage (
    .clk   (aclk),
    .we1_i (push_ok && (in_valid1_i || in_valid2_i)),
    .wa1_i (tail_q),
    .wd1_i (in_valid1_i ? {in_inst1_i, in_addr1_i} : {in_inst2_i, in_addr2_i}),
    .we2_i (push_ok && in_valid1_i && in_valid2_i),
    .wa2_i (tail_q + PW'(1)),
    .wd2_i ({in_inst2_i, in_addr2_i}),
    .ra1_i (head_q),
    .rd1_o (rd1),
    .ra2_i (head_q + PW'(1)),
    .rd2_o (rd2)
  );
  assign out_valid1_o = count_q != '0;
  assign out_valid2_o = count_q > CW'(1);
  assign out_inst1_o = out_valid1_o ? rd1[IW+AW-1:AW] : '0;
  assign out_addr1_o = out_valid1_o ? rd1[AW-1:0] : '0;
  assign out_inst2_o = out_valid2_o ? rd2[IW+AW-1:AW] : '0;
  assign out_addr2_o = out_valid2_o ? rd2[AW-1:0] : '0;
  assign count_o = count_q;
endmodule
